// File: rtl/instr_prefetch.sv
// Instruction prefetch buffer.
// Streams word-addressed fetches into a small FIFO of {pc, ins} entries.
// The consumer sees a registered head entry with a valid/ready handshake.
// A redirect from execute flushes the buffer and restarts fetch at a new pc.
module instr_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstd,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ins_valid,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    input  logic        ins_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [31:0]   last_ins;
    logic [31:0]   last_pc;

    logic [31:0]   mem_ins [DEPTH];
    logic [31:0]   mem_pc  [DEPTH];

    logic          pop;
    logic          wr_en;
    logic [CW:0]   occupancy;

    // Handshake and request gating: a request is only issued when the slot
    // it will eventually occupy is guaranteed free, counting the entry that
    // is leaving this cycle and the response already on its way.
    assign ins_valid = (count != '0);
    assign pop       = ins_valid & ins_ready;
    assign wr_en     = inflight & ~redirect;
    assign occupancy = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
    assign imem_req  = ~rstd & ~redirect & (occupancy < DEPTH_W);
    assign imem_addr = fetch_pc[7:0];

    // Head entry comes straight from buffer registers; when empty the last
    // shown entry is held so the outputs never glitch to stale storage.
    assign ins    = ins_valid ? mem_ins[rd_ptr] : last_ins;
    assign ins_pc = ins_valid ? mem_pc[rd_ptr]  : last_pc;

    // Fetch pointer, FIFO bookkeeping, in-flight tracking and held head.
    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            fetch_pc    <= RESET_PC;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            last_ins    <= '0;
            last_pc     <= '0;
        end else begin
            if (ins_valid) begin
                last_ins <= mem_ins[rd_ptr];
                last_pc  <= mem_pc[rd_ptr];
            end
            if (redirect) begin
                // Flush wins over any pop or arriving response this cycle.
                fetch_pc <= redirect_pc;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                inflight <= 1'b0;
            end else begin
                inflight <= imem_req;
                if (imem_req) begin
                    inflight_pc <= fetch_pc;
                    fetch_pc    <= fetch_pc + 32'd1;
                end
                if (wr_en) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(wr_en) - CW'(pop);
            end
        end
    end

    // Buffer storage: written with the response one cycle after its request.
    // NOTE: the storage array has no reset; count and pointers alone decide
    // which entries are meaningful, so clearing the data would be wasted logic.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_ins[wr_ptr] <= imem_data;
            mem_pc[wr_ptr]  <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed testbench for instr_prefetch (DEPTH=4, RESET_PC=0).
// Instruction memory model returns 0x100 + word address, one cycle late.
module tb_instr_prefetch;

    logic        clk;
    logic        rstd;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_ready;

    int tests;
    int fails;
    int req_total;
    int req_base;

    instr_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rstd       (rstd),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .ins_valid  (ins_valid),
        .ins        (ins),
        .ins_pc     (ins_pc),
        .ins_ready  (ins_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction memory: data for the address seen at an edge
    // is presented during the following cycle.
    always @(posedge clk) imem_data <= 32'h100 + {24'h0, imem_addr};

    // Running total of issued requests.
    always @(posedge clk) if (imem_req) req_total <= req_total + 1;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        req_total   = 0;
        rstd        = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        ins_ready   = 1'b1;

        // ---------------- reset state ----------------
        next_cycle();
        next_cycle();
        #1;
        check("rst_valid", 32'(ins_valid), 32'd0);
        check("rst_req",   32'(imem_req),  32'd0);
        check("rst_ins",   ins,            32'h0);
        check("rst_pc",    ins_pc,         32'h0);

        // ---------------- streaming ----------------
        rstd = 1'b0;
        #1;
        check("str_req0",  32'(imem_req),  32'd1);
        check("str_addr0", 32'(imem_addr), 32'h00);
        check("str_v0",    32'(ins_valid), 32'd0);
        next_cycle(); #1;
        check("str_addr1", 32'(imem_addr), 32'h01);
        check("str_v1",    32'(ins_valid), 32'd0);
        next_cycle(); #1;
        for (int k = 0; k < 8; k++) begin
            check("str_valid", 32'(ins_valid), 32'd1);
            check("str_pc",    ins_pc,         32'(k));
            check("str_ins",   ins,            32'h100 + 32'(k));
            next_cycle(); #1;
        end

        // ---------------- backpressure ----------------
        rstd      = 1'b1;
        ins_ready = 1'b0;
        #1;
        check("bp_rst_valid", 32'(ins_valid), 32'd0);
        next_cycle();
        rstd     = 1'b0;
        req_base = req_total;
        for (int i = 1; i <= 8; i++) begin
            next_cycle(); #1;
            if (i >= 2) begin
                check("bp_hold_valid", 32'(ins_valid), 32'd1);
                check("bp_hold_pc",    ins_pc,         32'h0);
            end
        end
        check("bp_req_count", 32'(req_total - req_base), 32'd4);
        check("bp_req_off",   32'(imem_req),             32'd0);
        check("bp_head_ins",  ins,                       32'h100);
        ins_ready = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            check("bp_drain_valid", 32'(ins_valid), 32'd1);
            check("bp_drain_pc",    ins_pc,         32'(k));
            next_cycle(); #1;
        end

        // ---------------- redirect with count=3 and one in flight ----------------
        rstd      = 1'b1;
        ins_ready = 1'b0;
        next_cycle();
        rstd = 1'b0;
        repeat (4) next_cycle();
        #1;
        check("rd_pre_valid", 32'(ins_valid), 32'd1);
        check("rd_pre_pc",    ins_pc,         32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h20;
        #1;
        check("rd_R_req", 32'(imem_req), 32'd0);
        next_cycle();
        redirect = 1'b0;
        #1;
        check("rd_R1_valid", 32'(ins_valid), 32'd0);
        check("rd_R1_holdpc", ins_pc,        32'h0);
        check("rd_R1_holdins", ins,          32'h100);
        check("rd_R1_req",   32'(imem_req),  32'd1);
        check("rd_R1_addr",  32'(imem_addr), 32'h20);
        next_cycle(); #1;
        check("rd_R2_valid", 32'(ins_valid), 32'd0);
        ins_ready = 1'b1;
        next_cycle(); #1;
        check("rd_R3_valid", 32'(ins_valid), 32'd1);
        check("rd_R3_pc",    ins_pc,         32'h20);
        check("rd_R3_ins",   ins,            32'h120);
        for (int k = 1; k <= 3; k++) begin
            next_cycle(); #1;
            check("rd_seq_pc", ins_pc, 32'h20 + 32'(k));
        end

        // ---------------- redirect with a simultaneous pop ----------------
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #1;
        check("rp_R_valid", 32'(ins_valid), 32'd1);
        next_cycle();
        redirect = 1'b0;
        #1;
        check("rp_R1_valid", 32'(ins_valid), 32'd0);
        check("rp_R1_addr",  32'(imem_addr), 32'h40);
        next_cycle(); #1;
        check("rp_R2_valid", 32'(ins_valid), 32'd0);
        next_cycle(); #1;
        check("rp_R3_pc",  ins_pc, 32'h40);
        check("rp_R3_ins", ins,    32'h140);
        next_cycle(); #1;
        check("rp_R4_pc",  ins_pc, 32'h41);

        // ---------------- redirect held for two cycles ----------------
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h50;
        #1;
        check("rh_R0_req", 32'(imem_req), 32'd0);
        next_cycle();
        redirect_pc = 32'h60;
        #1;
        check("rh_R1_req",   32'(imem_req),  32'd0);
        check("rh_R1_valid", 32'(ins_valid), 32'd0);
        next_cycle();
        redirect = 1'b0;
        #1;
        check("rh_addr", 32'(imem_addr), 32'h60);
        next_cycle();
        next_cycle(); #1;
        check("rh_pc",  ins_pc, 32'h60);
        check("rh_ins", ins,    32'h160);

        // ---------------- wrap-around ----------------
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        next_cycle();
        redirect = 1'b0;
        #1;
        check("wr_addr_fe", 32'(imem_addr), 32'hFE);
        next_cycle(); #1;
        check("wr_addr_ff", 32'(imem_addr), 32'hFF);
        next_cycle(); #1;
        check("wr_addr_00", 32'(imem_addr), 32'h00);
        check("wr_pc_fe",   ins_pc,         32'hFFFF_FFFE);
        check("wr_ins_fe",  ins,            32'h1FE);
        next_cycle(); #1;
        check("wr_pc_ff",   ins_pc,         32'hFFFF_FFFF);
        check("wr_ins_ff",  ins,            32'h1FF);
        next_cycle(); #1;
        check("wr_pc_00",   ins_pc,         32'h0000_0000);
        check("wr_ins_00",  ins,            32'h100);

        // ---------------- reset while full ----------------
        next_cycle();
        ins_ready = 1'b0;
        repeat (6) next_cycle();
        #1;
        check("rf_full_valid", 32'(ins_valid), 32'd1);
        check("rf_full_req",   32'(imem_req),  32'd0);
        rstd = 1'b1;
        #1;
        check("rf_rst_valid", 32'(ins_valid), 32'd0);
        check("rf_rst_req",   32'(imem_req),  32'd0);
        check("rf_rst_ins",   ins,            32'h0);
        check("rf_rst_pc",    ins_pc,         32'h0);
        next_cycle();
        rstd      = 1'b0;
        ins_ready = 1'b1;
        #1;
        check("rf_c0_req",  32'(imem_req),  32'd1);
        check("rf_c0_addr", 32'(imem_addr), 32'h00);
        next_cycle(); #1;
        check("rf_c1_valid", 32'(ins_valid), 32'd0);
        next_cycle(); #1;
        check("rf_c2_valid", 32'(ins_valid), 32'd1);
        check("rf_c2_pc",    ins_pc,         32'h0);
        check("rf_c2_ins",   ins,            32'h100);
        next_cycle(); #1;
        check("rf_c3_pc",    ins_pc,         32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 The block SHALL take parameter DEPTH, default 4, as the number of instruction-buffer entries (power of two, 2..16).
REQ-002 The block SHALL take parameter RESET_PC, default 32'h00000000, as the fetch word address loaded on reset.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rstd  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port imem_req  output  1  instruction-memory read request this cycle.
REQ-006 The block SHALL have port imem_addr  output  8  word address for the request, equal to fetch_pc[7:0].
REQ-007 The block SHALL have port imem_data  input  32  read data, valid in the cycle after imem_req.
REQ-008 The block SHALL have port redirect  input  1  taken branch, jump or jr from the execute stage.
REQ-009 The block SHALL have port redirect_pc  input  32  new fetch word address, sampled when redirect=1.
REQ-010 The block SHALL have port ins_valid  output  1  the head buffer entry is valid.
REQ-011 The block SHALL have port ins  output  32  instruction word at the head of the buffer.
REQ-012 The block SHALL have port ins_pc  output  32  word address of ins.
REQ-013 The block SHALL have port ins_ready  input  1  the consumer accepts the head entry this cycle.

Function
REQ-014 The block SHALL hold a 32-bit fetch_pc, a FIFO of DEPTH {pc,ins} entries, a count, and one in-flight flag with its captured pc.
REQ-015 The block SHALL set imem_req=1 when (count + inflight - pop) < DEPTH and redirect=0, where pop = ins_valid & ins_ready.
REQ-016 On each issued request the block SHALL set fetch_pc <= fetch_pc + 1 (word addressing), wrapping 32'hFFFFFFFF to 0.
REQ-017 A request issued in cycle C SHALL write {issue pc, imem_data} into the FIFO tail at the end of C+1; that entry is visible at the head no earlier than C+2.
REQ-018 The FIFO SHALL NOT bypass imem_data to ins. ins and ins_pc SHALL come from registers.
REQ-019 Entries SHALL leave the buffer in issue order. A pop and a write in the same cycle SHALL leave count unchanged.
REQ-020 When the consumer is always ready and no redirect occurs, the block SHALL sustain one instruction per cycle after the first fill.
REQ-021 When count=DEPTH, no request SHALL be issued. When count=0, ins_valid SHALL be 0 and ins/ins_pc SHALL hold their last values.
REQ-022 When redirect=1 in cycle R, at the end of R the block SHALL set count to 0, discard the pending in-flight response, and set fetch_pc to redirect_pc.
REQ-023 A pop in cycle R SHALL have no further effect because the flush overrides it. The first request at redirect_pc SHALL issue in R+1, and ins_valid SHALL return in R+3.
REQ-024 If redirect is held asserted for several cycles, the block SHALL flush in each of them and SHALL use the last redirect_pc.
REQ-025 When ins_valid=1 and ins_ready=0, ins and ins_pc SHALL remain stable.

Reset
REQ-026 While rstd=1, asynchronously: fetch_pc=RESET_PC, count=0, inflight=0, imem_req=0, ins_valid=0, ins=0, ins_pc=0.
REQ-027 Reset asserted mid-operation SHALL discard every buffered and in-flight instruction. The response that arrives after reset SHALL be ignored.
REQ-028 After rstd falls, the first request at RESET_PC SHALL issue in the first clock cycle, and ins_valid SHALL rise two cycles later.

Verification
REQ-029 The bench SHALL cover a streaming case: release reset with ins_ready=1 and imem[k]=k+0x100. Required response: ins_pc 0,1,2,... with ins 0x100,0x101,... on consecutive cycles from cycle 2, with no gaps.
REQ-030 The bench SHALL cover a backpressure case: hold ins_ready=0 with DEPTH=4. Required response: exactly 4 requests, count=4, imem_req=0 after that, and head ins_pc=0 stable. Raising ins_ready SHALL then drain 0,1,2,3,... in order.
REQ-031 The bench SHALL cover a redirect case: redirect=1 with redirect_pc=0x20 while count=3 and one request is in flight. Required response: the next ins_valid occurs 3 cycles later with ins_pc=0x20, and no stale pc ever appears.
REQ-032 The bench SHALL cover redirect together with a pop: ins_valid=ins_ready=redirect=1 in the same cycle. Required response: buffer empty, and the following entries start at redirect_pc.
REQ-033 The bench SHALL cover wrap-around: redirect_pc=32'hFFFFFFFE. Required response: ins_pc sequence FFFFFFFE, FFFFFFFF, 00000000, with imem_addr FE, FF, 00.
REQ-034 The bench SHALL cover reset mid-stream: assert rstd for 1 cycle while full. Required response: ins_valid=0 immediately, and the restart delivers ins_pc=RESET_PC first.
